// File: rtl/bin_pkg.sv
// rtl/bin_pkg.sv - state encoding and default widths shared by the bin loader and store engine
package bin_pkg;

    localparam int DEF_NUM_VARS_A_BIN         = 8;
    localparam int DEF_NUM_LVLS_A_BIN         = 8;
    localparam int DEF_WIDTH_VAR              = 12;
    localparam int DEF_WIDTH_LVL              = 16;
    localparam int DEF_WIDTH_BIN_ID           = 10;
    localparam int DEF_WIDTH_VAR_STATES       = 19;
    localparam int DEF_WIDTH_LVL_STATES       = 11;
    localparam int DEF_ADDR_WIDTH_VAR         = 9;
    localparam int DEF_ADDR_WIDTH_VARS_STATES = 9;
    localparam int DEF_ADDR_WIDTH_LVLS_STATES = 9;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STORE_VS = 2'd1,
        STORE_LS = 2'd2,
        DONE     = 2'd3
    } store_state_t;

endpackage

// File: rtl/gather_from_8_datas.sv
// rtl/gather_from_8_datas.sv - select one WIDTH-bit word out of a packed 8-word vector
module gather_from_8_datas #(
    parameter int WIDTH = 8
) (
    input  logic [8*WIDTH-1:0] i_datas,
    input  logic [2:0]         i_idx,
    output logic [WIDTH-1:0]   o_data
);

    logic [WIDTH-1:0] w_words [8];

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_split
            assign w_words[g] = i_datas[g*WIDTH +: WIDTH];
        end
    endgenerate

    assign o_data = w_words[i_idx];

endmodule

// File: rtl/store_bin.sv
// rtl/store_bin.sv - write one bin's var and lvl states back to shared BRAM
module store_bin
    import bin_pkg::*;
#(
    parameter int NUM_VARS_A_BIN         = DEF_NUM_VARS_A_BIN,
    parameter int NUM_LVLS_A_BIN         = DEF_NUM_LVLS_A_BIN,
    parameter int WIDTH_VAR              = DEF_WIDTH_VAR,
    parameter int WIDTH_LVL              = DEF_WIDTH_LVL,
    parameter int WIDTH_BIN_ID           = DEF_WIDTH_BIN_ID,
    parameter int WIDTH_VAR_STATES       = DEF_WIDTH_VAR_STATES,
    parameter int WIDTH_LVL_STATES       = DEF_WIDTH_LVL_STATES,
    parameter int ADDR_WIDTH_VAR         = DEF_ADDR_WIDTH_VAR,
    parameter int ADDR_WIDTH_VARS_STATES = DEF_ADDR_WIDTH_VARS_STATES,
    parameter int ADDR_WIDTH_LVLS_STATES = DEF_ADDR_WIDTH_LVLS_STATES
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start_store,
    input  logic [WIDTH_BIN_ID-1:0]                      bin_num_i,
    input  logic [WIDTH_LVL-1:0]                         base_lvl_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]   vars_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]   lvl_states_i,
    output logic                                         apply_store_o,
    output logic                                         done_store,
    output logic [ADDR_WIDTH_VAR-1:0]                    ram_addr_v_o,
    input  logic [WIDTH_VAR-1:0]                         ram_data_v_i,
    output logic                                         ram_we_vs_o,
    output logic [ADDR_WIDTH_VARS_STATES-1:0]            ram_addr_vs_o,
    output logic [WIDTH_VAR_STATES-1:0]                  ram_data_vs_o,
    output logic                                         ram_we_ls_o,
    output logic [ADDR_WIDTH_LVLS_STATES-1:0]            ram_addr_ls_o,
    output logic [WIDTH_LVL_STATES-1:0]                  ram_data_ls_o
);

    localparam int VCNT_W = $clog2(NUM_VARS_A_BIN + 1);
    localparam int LCNT_W = $clog2(NUM_LVLS_A_BIN);
    localparam logic [VCNT_W-1:0] VCNT_END  = VCNT_W'(NUM_VARS_A_BIN);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(NUM_LVLS_A_BIN - 1);

    store_state_t                                r_state;
    logic [VCNT_W-1:0]                           r_vcnt;
    logic [LCNT_W-1:0]                           r_lcnt;
    logic                                        r_rd_valid;
    logic [2:0]                                  r_rd_idx;
    logic [ADDR_WIDTH_VAR-1:0]                   r_vbase;
    logic [WIDTH_LVL-1:0]                        r_lbase;
    logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]  r_vs_snap;
    logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]  r_ls_snap;

    logic                                        w_vs_issue;
    logic                                        w_ls_active;
    logic [WIDTH_VAR_STATES-1:0]                 w_vs_word;
    logic [WIDTH_LVL_STATES-1:0]                 w_ls_word;

    assign w_vs_issue  = (r_state == STORE_VS) && (r_vcnt != VCNT_END);
    assign w_ls_active = (r_state == STORE_LS);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_vcnt     <= '0;
            r_lcnt     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_idx   <= '0;
            r_vbase    <= '0;
            r_lbase    <= '0;
            r_vs_snap  <= '0;
            r_ls_snap  <= '0;
        end else begin
            // The read pipe tracks which slot's var id comes back next cycle.
            r_rd_valid <= w_vs_issue;
            r_rd_idx   <= 3'(r_vcnt);
            case (r_state)
                IDLE: begin
                    r_vcnt <= '0;
                    r_lcnt <= '0;
                    if (start_store) begin
                        r_vbase   <= ADDR_WIDTH_VAR'(bin_num_i * NUM_VARS_A_BIN);
                        r_lbase   <= base_lvl_i;
                        r_vs_snap <= vars_states_i;
                        r_ls_snap <= lvl_states_i;
                        r_state   <= STORE_VS;
                    end
                end
                STORE_VS: begin
                    if (r_vcnt != VCNT_END) begin
                        r_vcnt <= r_vcnt + 1'b1;
                    end else begin
                        r_lcnt  <= '0;
                        r_state <= STORE_LS;
                    end
                end
                STORE_LS: begin
                    r_lcnt <= r_lcnt + 1'b1;
                    if (r_lcnt == LCNT_LAST) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    gather_from_8_datas #(.WIDTH(WIDTH_VAR_STATES)) u_gather_vs (
        .i_datas (r_vs_snap),
        .i_idx   (r_rd_idx),
        .o_data  (w_vs_word)
    );

    gather_from_8_datas #(.WIDTH(WIDTH_LVL_STATES)) u_gather_ls (
        .i_datas (r_ls_snap),
        .i_idx   (3'(r_lcnt)),
        .o_data  (w_ls_word)
    );

    assign apply_store_o = (r_state != IDLE);
    assign done_store    = (r_state == DONE);

    assign ram_addr_v_o  = w_vs_issue ? (r_vbase + ADDR_WIDTH_VAR'(r_vcnt)) : '0;

    // Var id 0 is an empty slot and must never reach the vars-states RAM.
    assign ram_we_vs_o   = r_rd_valid && (ram_data_v_i != '0);
    assign ram_addr_vs_o = r_rd_valid ? ADDR_WIDTH_VARS_STATES'(ram_data_v_i) : '0;
    assign ram_data_vs_o = r_rd_valid ? w_vs_word : '0;

    assign ram_we_ls_o   = w_ls_active;
    assign ram_addr_ls_o = w_ls_active ? ADDR_WIDTH_LVLS_STATES'(r_lbase + WIDTH_LVL'(r_lcnt)) : '0;
    assign ram_data_ls_o = w_ls_active ? w_ls_word : '0;

endmodule

// File: doc/store_bin.md
Name: store_bin

Overview:
- Write-back engine for one bin, run before the SAT engine swaps in another bin.
- Snapshots the engine's per-slot var states and lvl states, then writes them to shared BRAM:
  - var states go to the vars-states RAM, addressed indirectly through the vars-bin RAM (slot -> global var id);
  - lvl states go to the lvls-states RAM at base_lvl+i.
- Arbitrated with the bin loader through the apply_store_o mux signal.

Parameters:
- NUM_VARS_A_BIN, 8, var slots per bin
- NUM_LVLS_A_BIN, 8, lvl slots per bin
- WIDTH_VAR, 12, global var id width
- WIDTH_LVL, 16, level number width
- WIDTH_BIN_ID, 10, bin id width
- WIDTH_VAR_STATES, 19, one var state word
- WIDTH_LVL_STATES, 11, one lvl state word
- ADDR_WIDTH_VAR, 9, vars-bin RAM address width
- ADDR_WIDTH_VARS_STATES, 9, vars-states RAM address width
- ADDR_WIDTH_LVLS_STATES, 9, lvls-states RAM address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start_store  in  1  one-cycle request, sampled in IDLE only
- bin_num_i  in  WIDTH_BIN_ID  bin being stored
- base_lvl_i  in  WIDTH_LVL  lowest level held by the bin
- vars_states_i  in  WIDTH_VAR_STATES*NUM_VARS_A_BIN  packed engine var states, slot 0 in LSBs
- lvl_states_i  in  WIDTH_LVL_STATES*NUM_LVLS_A_BIN  packed engine lvl states, slot 0 in LSBs
- apply_store_o  out  1  high while busy, drives the BRAM mux
- done_store  out  1  one-cycle completion pulse
- ram_addr_v_o  out  ADDR_WIDTH_VAR  vars-bin RAM read address
- ram_data_v_i  in  WIDTH_VAR  var id; valid 1 cycle after address
- ram_we_vs_o  out  1  vars-states write enable
- ram_addr_vs_o  out  ADDR_WIDTH_VARS_STATES  vars-states write address
- ram_data_vs_o  out  WIDTH_VAR_STATES  vars-states write data
- ram_we_ls_o  out  1  lvls-states write enable
- ram_addr_ls_o  out  ADDR_WIDTH_LVLS_STATES  lvls-states write address
- ram_data_ls_o  out  WIDTH_LVL_STATES  lvls-states write data

Behaviour:
- Reset: rst=0 at a clock edge forces state IDLE, all counters 0, snapshots 0, and every output 0 (all enables, addresses, data, apply_store_o, done_store).
- States: IDLE -> STORE_VS -> STORE_LS -> DONE -> IDLE.
- IDLE, on start_store (captured at edge T0):
  - latch vbase = (bin_num_i*NUM_VARS_A_BIN) truncated to ADDR_WIDTH_VAR;
  - latch lbase = base_lvl_i;
  - latch both state vectors as snapshots. Later input changes have no effect.
- start_store outside IDLE is ignored.
- STORE_VS (T1..):
  - ram_addr_v_o = vbase+vcnt, vcnt 0..NUM_VARS_A_BIN-1, one per cycle; vcnt saturates at NUM_VARS_A_BIN.
  - A one-stage pipe (rd_valid, rd_idx) marks the returning id.
  - In the returning cycle: ram_addr_vs_o = ram_data_v_i; ram_data_vs_o = vs_snap[rd_idx]; ram_we_vs_o = rd_valid && ram_data_v_i!=0.
  - Var id 0 marks an empty slot and is never written.
  - Exit to STORE_LS when vcnt==NUM_VARS_A_BIN; the final write happens in that exit cycle.
- STORE_LS:
  - ram_we_ls_o=1 every cycle.
  - ram_addr_ls_o = (lbase+lcnt) truncated to ADDR_WIDTH_LVLS_STATES; wraps modulo 2^ADDR_WIDTH.
  - ram_data_ls_o = ls_snap[lcnt], lcnt 0..NUM_LVLS_A_BIN-1.
  - Exit after lcnt==NUM_LVLS_A_BIN-1.
- DONE: done_store=1 for exactly this cycle, then IDLE.
- apply_store_o = (state!=IDLE).
- Write enables are never high outside their own phase, and vs/ls writes never overlap.
- Ram addresses are 0 when the matching phase is idle.
- Latency with defaults 8/8:
  - vs writes at T2..T9;
  - ls writes at T10..T17;
  - done_store at T18;
  - accepts a new start_store from T19.
- Reset mid-operation: abort immediately, no further writes, no done_store.

Decomposition:
- Shared package bin_pkg: state encoding (IDLE, STORE_VS, STORE_LS, DONE) and the default width constants shared with the bin loader.
- One natural sub-module, gather_from_8_datas: a parameterised WIDTH mux that selects element idx from a packed 8-word vector. It is the inverse of the loader's scatter, and is instantiated once for var states and once for lvl states.

Test Plan:
- bin_num=2, vars-bin RAM[16..23]={5,6,0,7,9,10,11,12}, vs_snap[i]=0x100+i -> writes (5,0x100), (6,0x101), slot 2 skipped, (7,0x103)...(12,0x107) at T2..T9 with slot 2's cycle at T4.
- base_lvl_i=3, lvl_states[i]=0x40+i -> ls writes addr 3..10 data 0x40..0x47 at T10..T17; done_store only at T18; apply_store_o high T1..T18.
- Change vars_states_i/lvl_states_i to all-ones at T1 -> written data still equals T0 values.
- base_lvl_i=510 with 9-bit addresses -> ls addresses 510,511,0,1,2,3,4,5.
- start_store pulsed at T12 -> ignored, single done_store. Second start_store at T19 -> a full second sequence runs.
- rst=0 at T5 -> from T6 all enables 0, state IDLE, apply_store_o=0, no done_store; a subsequent start_store runs normally.
